// File: rtl/dp_sram_be.sv
// dp_sram_be: simple-dual-port SRAM with per-byte write enables,
// write-first collision forwarding, read latency 1 or 2, a one-cycle
// read-valid strobe and a zero-fill init sequencer that runs after reset.
// Optional build macro: DP_SRAM_PARITY_EN adds per-byte even parity and oParErr.
//
// state | meaning
// INIT  | writing zero to mem[cnt_q]; user requests ignored, oInitBusy high
// RUN   | normal operation; left only through iRst
module dp_sram_be #(
    parameter  int SRAM_DEPTH = 16,
    parameter  int DATA_WIDTH = 32,
    parameter  int RD_LATENCY = 1,
    localparam int AW         = (SRAM_DEPTH > 2) ? $clog2(SRAM_DEPTH) : 1,
    localparam int BW         = DATA_WIDTH / 8
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iWrCsn,
    input  logic [AW-1:0]         iWrAddr,
    input  logic [BW-1:0]         iWrBe,
    input  logic [DATA_WIDTH-1:0] iWrDt,
    input  logic                  iRdCsn,
    input  logic [AW-1:0]         iRdAddr,
    output logic [DATA_WIDTH-1:0] oRdDt,
    output logic                  oRdVld,
`ifdef DP_SRAM_PARITY_EN
    output logic                  oParErr,
`endif
    output logic                  oInitBusy
);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("dp_sram_be: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("dp_sram_be: DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(SRAM_DEPTH - 1);
    // One extra bit so the range compare is meaningful for power-of-2 depths too.
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(SRAM_DEPTH);

    state_e                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [SRAM_DEPTH];
    logic                    run, wr_en, rd_acc, rd_hit;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    s_vld;
    logic [DATA_WIDTH-1:0]   s_dt;
    logic                    rd_vld_q;
    logic [DATA_WIDTH-1:0]   rd_dt_q;
`ifdef DP_SRAM_PARITY_EN
    // Stored parity is a plain array so a bench can flip bits hierarchically.
    logic [BW-1:0]           par_q [SRAM_DEPTH];
    logic                    rd_err, s_err, par_err_q;
`endif

    // FSM state and init counter register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: sweep every address once, then run forever
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    // Request decode and write-first read word (out-of-range reads give zero)
    always_comb begin
        run     = (state_q == ST_RUN);
        wr_en   = run && !iWrCsn && ({1'b0, iWrAddr} < DEPTH_W);
        rd_acc  = run && !iRdCsn;
        rd_hit  = wr_en && (iWrAddr == iRdAddr);
        rd_word = '0;
`ifdef DP_SRAM_PARITY_EN
        rd_err  = 1'b0;
`endif
        if ({1'b0, iRdAddr} < DEPTH_W) begin
            rd_word = mem_q[iRdAddr];
            for (int b = 0; b < BW; b++) begin
                if (rd_hit && iWrBe[b]) begin
                    rd_word[8*b +: 8] = iWrDt[8*b +: 8];
`ifdef DP_SRAM_PARITY_EN
                end else if ((^mem_q[iRdAddr][8*b +: 8]) != par_q[iRdAddr][b]) begin
                    rd_err = 1'b1;
`endif
                end
            end
        end
    end

    // Storage array: zero-fill during INIT, byte-masked writes during RUN
    always_ff @(posedge iClk) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= '0;
`ifdef DP_SRAM_PARITY_EN
            par_q[cnt_q] <= '0;
`endif
        end else if (wr_en) begin
            for (int b = 0; b < BW; b++) begin
                if (iWrBe[b]) begin
                    mem_q[iWrAddr][8*b +: 8] <= iWrDt[8*b +: 8];
`ifdef DP_SRAM_PARITY_EN
                    par_q[iWrAddr][b] <= ^iWrDt[8*b +: 8];
`endif
                end
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  p_vld_q;
        logic [DATA_WIDTH-1:0] p_dt_q;
`ifdef DP_SRAM_PARITY_EN
        logic                  p_err_q;
`endif
        // Extra read pipeline stage for the two-cycle latency option
        always_ff @(posedge iClk or posedge iRst) begin
            if (iRst) begin
                p_vld_q <= 1'b0;
                p_dt_q  <= '0;
`ifdef DP_SRAM_PARITY_EN
                p_err_q <= 1'b0;
`endif
            end else begin
                p_vld_q <= rd_acc;
                if (rd_acc) begin
                    p_dt_q <= rd_word;
                end
`ifdef DP_SRAM_PARITY_EN
                p_err_q <= rd_acc && rd_err;
`endif
            end
        end
        assign s_vld = p_vld_q;
        assign s_dt  = p_dt_q;
`ifdef DP_SRAM_PARITY_EN
        assign s_err = p_err_q;
`endif
    end else begin : g_lat1
        assign s_vld = rd_acc;
        assign s_dt  = rd_word;
`ifdef DP_SRAM_PARITY_EN
        assign s_err = rd_err;
`endif
    end

    // Output stage: data holds between strobes
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rd_vld_q  <= 1'b0;
            rd_dt_q   <= '0;
`ifdef DP_SRAM_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            rd_vld_q <= s_vld;
            if (s_vld) begin
                rd_dt_q <= s_dt;
            end
`ifdef DP_SRAM_PARITY_EN
            par_err_q <= s_vld && s_err;
`endif
        end
    end

    assign oRdDt     = rd_dt_q;
    assign oRdVld    = rd_vld_q;
    assign oInitBusy = (state_q == ST_INIT);
`ifdef DP_SRAM_PARITY_EN
    assign oParErr   = par_err_q;
`endif

endmodule

// File: tb/tb_dp_sram_be.sv
// Bench for dp_sram_be: three instances share one stimulus stream
// (depth 16 / latency 1, depth 16 / latency 2, depth 12 / latency 1)
// and are compared against a word-level memory model every cycle.
module tb_dp_sram_be;

    logic        clk;
    logic        rst;
    logic        wr_csn;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_dt;
    logic        rd_csn;
    logic [3:0]  rd_addr;

    logic [31:0] dt1, dt2, dt12;
    logic        vld1, vld2, vld12;
    logic        busy1, busy2, busy12;
`ifdef DP_SRAM_PARITY_EN
    logic        perr1, perr2, perr12;
`endif

    dp_sram_be #(.SRAM_DEPTH(16), .DATA_WIDTH(32), .RD_LATENCY(1)) u_l1 (
        .iClk(clk), .iRst(rst), .iWrCsn(wr_csn), .iWrAddr(wr_addr), .iWrBe(wr_be),
        .iWrDt(wr_dt), .iRdCsn(rd_csn), .iRdAddr(rd_addr), .oRdDt(dt1), .oRdVld(vld1),
`ifdef DP_SRAM_PARITY_EN
        .oParErr(perr1),
`endif
        .oInitBusy(busy1));

    dp_sram_be #(.SRAM_DEPTH(16), .DATA_WIDTH(32), .RD_LATENCY(2)) u_l2 (
        .iClk(clk), .iRst(rst), .iWrCsn(wr_csn), .iWrAddr(wr_addr), .iWrBe(wr_be),
        .iWrDt(wr_dt), .iRdCsn(rd_csn), .iRdAddr(rd_addr), .oRdDt(dt2), .oRdVld(vld2),
`ifdef DP_SRAM_PARITY_EN
        .oParErr(perr2),
`endif
        .oInitBusy(busy2));

    dp_sram_be #(.SRAM_DEPTH(12), .DATA_WIDTH(32), .RD_LATENCY(1)) u_d12 (
        .iClk(clk), .iRst(rst), .iWrCsn(wr_csn), .iWrAddr(wr_addr), .iWrBe(wr_be),
        .iWrDt(wr_dt), .iRdCsn(rd_csn), .iRdAddr(rd_addr), .oRdDt(dt12), .oRdVld(vld12),
`ifdef DP_SRAM_PARITY_EN
        .oParErr(perr12),
`endif
        .oInitBusy(busy12));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word memory, init-cycle countdowns, expected outputs
    logic [31:0] m_mem [16];
    int          left16, left12;
    logic        e1_vld, e2_vld, e12_vld, p2_vld;
    logic [31:0] e1_dt, e2_dt, e12_dt, p2_dt;

    int checks;
    int failures;

    typedef struct {
        logic        wcsn;
        logic [3:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        rcsn;
        logic [3:0]  ra;
        logic        evld;
        logic [31:0] edt;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 16; a++) m_mem[a] = 32'h0;
        left16  = 16;
        left12  = 12;
        e1_vld  = 1'b0; e2_vld = 1'b0; e12_vld = 1'b0; p2_vld = 1'b0;
        e1_dt   = 32'h0; e2_dt = 32'h0; e12_dt = 32'h0; p2_dt = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] val, mask;
        logic        acc, acc12;
        if (rst) begin
            model_reset();
            return;
        end
        mask = be_mask(wr_be);
        val  = m_mem[rd_addr];
        if (left16 == 0 && !wr_csn && wr_addr == rd_addr)
            val = (val & ~mask) | (wr_dt & mask);
        acc   = (left16 == 0) && !rd_csn;
        acc12 = (left12 == 0) && !rd_csn;
        e2_vld = p2_vld;
        if (p2_vld) e2_dt = p2_dt;
        p2_vld = acc;
        if (acc) p2_dt = val;
        e1_vld = acc;
        if (acc) e1_dt = val;
        e12_vld = acc12;
        if (acc12) e12_dt = (rd_addr < 12) ? val : 32'h0;
        if (left16 == 0 && !wr_csn)
            m_mem[wr_addr] = (m_mem[wr_addr] & ~mask) | (wr_dt & mask);
        if (left16 > 0) left16--;
        if (left12 > 0) left12--;
    endtask

    task automatic compare_all();
        chk1("l1_vld", vld1, e1_vld);
        chk ("l1_dt", dt1, e1_dt);
        chk1("l1_busy", busy1, left16 > 0);
        chk1("l2_vld", vld2, e2_vld);
        chk ("l2_dt", dt2, e2_dt);
        chk1("l2_busy", busy2, left16 > 0);
        chk1("d12_vld", vld12, e12_vld);
        chk ("d12_dt", dt12, e12_dt);
        chk1("d12_busy", busy12, left12 > 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        wr_csn = 1'b1; wr_addr = 4'd0; wr_be = 4'd0; wr_dt = 32'h0;
        rd_csn = 1'b1; rd_addr = 4'd0;
    endtask

    task automatic rd(input logic [3:0] a);
        rd_csn = 1'b0; rd_addr = a;
    endtask

    task automatic run_init(input string name);
        int n;
        n = 0;
        while (busy1 && n < 100) begin
            n++;
            step();
            if (n == 1) idle();
        end
        chk(name, n, 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0]  = '{1'b1, 4'd0,  4'h0, 32'h0,        1'b0, 4'd0,  1'b1, 32'h0};
        vecs[1]  = '{1'b0, 4'd3,  4'hF, 32'hAABBCCDD, 1'b1, 4'd0,  1'b0, 32'h0};
        vecs[2]  = '{1'b0, 4'd3,  4'h5, 32'h11223344, 1'b1, 4'd0,  1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'd0,  4'h0, 32'h0,        1'b0, 4'd3,  1'b1, 32'hAA22CC44};
        vecs[4]  = '{1'b0, 4'd5,  4'hF, 32'h12345678, 1'b1, 4'd0,  1'b0, 32'hAA22CC44};
        vecs[5]  = '{1'b0, 4'd5,  4'h3, 32'hFFFFFFFF, 1'b0, 4'd5,  1'b1, 32'h1234FFFF};
        vecs[6]  = '{1'b1, 4'd0,  4'h0, 32'h0,        1'b0, 4'd5,  1'b1, 32'h1234FFFF};
        vecs[7]  = '{1'b0, 4'd6,  4'h0, 32'hDEADBEEF, 1'b0, 4'd6,  1'b1, 32'h0};
        vecs[8]  = '{1'b0, 4'd7,  4'hF, 32'hCAFEF00D, 1'b0, 4'd3,  1'b1, 32'hAA22CC44};
        vecs[9]  = '{1'b0, 4'd7,  4'h8, 32'h00000000, 1'b0, 4'd7,  1'b1, 32'h00FEF00D};
        vecs[10] = '{1'b1, 4'd0,  4'h0, 32'h0,        1'b1, 4'd0,  1'b0, 32'h00FEF00D};
        vecs[11] = '{1'b0, 4'd13, 4'hF, 32'h00000077, 1'b1, 4'd0,  1'b0, 32'h00FEF00D};
        vecs[12] = '{1'b1, 4'd0,  4'h0, 32'h0,        1'b0, 4'd13, 1'b1, 32'h00000077};
        vecs[13] = '{1'b0, 4'd0,  4'hF, 32'h00000010, 1'b1, 4'd0,  1'b0, 32'h00000077};
        vecs[14] = '{1'b0, 4'd1,  4'hF, 32'h00000011, 1'b0, 4'd0,  1'b1, 32'h00000010};
        vecs[15] = '{1'b0, 4'd2,  4'hF, 32'h00000012, 1'b0, 4'd1,  1'b1, 32'h00000011};
        vecs[16] = '{1'b0, 4'd12, 4'hF, 32'h00000099, 1'b0, 4'd2,  1'b1, 32'h00000012};
        vecs[17] = '{1'b1, 4'd0,  4'h0, 32'h0,        1'b0, 4'd12, 1'b1, 32'h00000099};
        vecs[18] = '{1'b0, 4'd3,  4'hF, 32'h00000000, 1'b0, 4'd3,  1'b1, 32'h0};
        vecs[19] = '{1'b1, 4'd0,  4'h0, 32'h0,        1'b0, 4'd3,  1'b1, 32'h0};

        // Reset values
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) step();
        chk1("rst_busy", busy1, 1'b1);
        chk1("rst_vld", vld1, 1'b0);
        chk ("rst_dt", dt1, 32'h0);

        // Init length; a write and read issued during INIT must be ignored
        rst     = 1'b0;
        wr_csn  = 1'b0; wr_addr = 4'd0; wr_be = 4'hF; wr_dt = 32'h55;
        rd(4'd0);
        run_init("init_cycles");

        // Every address reads back zero after init
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            step();
        end
        idle();
        step();

        // Directed vectors
        for (int i = 0; i < 20; i++) begin
            wr_csn = vecs[i].wcsn; wr_addr = vecs[i].wa; wr_be = vecs[i].be;
            wr_dt  = vecs[i].wd;   rd_csn  = vecs[i].rcsn; rd_addr = vecs[i].ra;
            step();
            chk1($sformatf("vec%0d_vld", i), vld1, vecs[i].evld);
            chk ($sformatf("vec%0d_dt", i), dt1, vecs[i].edt);
        end
        idle();
        repeat (2) step();

        // Latency-2 back-to-back reads of 0x10, 0x11, 0x12
        rd(4'd0); step();
        chk1("lat2_k_vld", vld2, 1'b0);
        rd(4'd1); step();
        chk1("lat2_k1_vld", vld2, 1'b1); chk("lat2_k1_dt", dt2, 32'h10);
        rd(4'd2); step();
        chk1("lat2_k2_vld", vld2, 1'b1); chk("lat2_k2_dt", dt2, 32'h11);
        idle(); step();
        chk1("lat2_k3_vld", vld2, 1'b1); chk("lat2_k3_dt", dt2, 32'h12);
        step();
        chk1("lat2_k4_vld", vld2, 1'b0); chk("lat2_hold_dt", dt2, 32'h12);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            wr_csn  = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            wr_be   = 4'($urandom);
            wr_dt   = $urandom;
            rd_csn  = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            step();
        end
        idle();
        repeat (2) step();

        // Reset with a latency-2 read in flight
        rd(4'd5); step();
        idle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk1("midrst_busy", busy1, 1'b1);
        chk1("midrst_vld2", vld2, 1'b0);
        @(negedge clk);
        repeat (2) step();
        rst = 1'b0;
        run_init("reinit_cycles");
        rd(4'd5); step();
        idle(); repeat (2) step();

`ifdef DP_SRAM_PARITY_EN
        wr_csn = 1'b0; wr_addr = 4'd7; wr_be = 4'hF; wr_dt = 32'hA5A50F0F;
        step();
        idle();
        u_l1.par_q[7][1] = ~u_l1.par_q[7][1];
        rd(4'd7); step();
        chk1("par_flip_vld", vld1, 1'b1);
        chk1("par_flip_err", perr1, 1'b1);
        rd(4'd3); step();
        chk1("par_clean_err", perr1, 1'b0);
        chk1("par_l2_err", perr2, 1'b0);
        chk1("par_d12_err", perr12, 1'b0);
        idle(); step();
        u_l1.par_q[7][1] = ~u_l1.par_q[7][1];
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
